sm_seq_divider: RTL

Multi-cycle sign-magnitude integer divider, generalised to W-bit magnitudes. It uses a restoring shift-subtract datapath that produces one quotient bit per clock, with a start/busy/done handshake. Quotient and remainder are returned in sign-magnitude form with truncation toward zero, and divide-by-zero is explicitly flagged. It is the next-generation arithmetic core of the divider tile; the top-level pin wrapper maps ui_in/uo_out onto it at W=3.

---
 rtl/sm_seq_divider.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sm_seq_divider.sv
// sm_seq_divider
//   Multi-cycle sign-magnitude integer divider. A restoring shift-subtract
//   datapath produces one quotient bit per clock, MSB first. Results are in
//   sign-magnitude form, truncated toward zero. A zero divisor is flagged and
//   bypasses the iteration entirely.
//
// Ports
//   clk, rst          : clock; asynchronous active-high reset
//   start             : request a division (sampled only while idle)
//   dividend_mag/sign : dividend operand (sign 1 = negative)
//   divisor_mag/sign  : divisor operand (sign 1 = negative)
//   busy              : high while a division is in progress (CALC, FIN)
//   done              : one-cycle pulse, results newly updated
//   quotient_mag/sign : registered quotient
//   remainder_mag/sign: registered remainder
//   div_by_zero       : registered, last completed operation had divisor 0
module sm_seq_divider #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend_mag,
  input  logic         dividend_sign,
  input  logic [W-1:0] divisor_mag,
  input  logic         divisor_sign,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient_mag,
  output logic         quotient_sign,
  output logic [W-1:0] remainder_mag,
  output logic         remainder_sign,
  output logic         div_by_zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Suppress negative zero: a sign only survives on a nonzero magnitude.
  function automatic logic sign_fix(input logic s, input logic [W-1:0] mag);
    return s & (|mag);
  endfunction

  // Control state
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Working datapath registers (no reset: only meaningful after an accept)
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic          dvd_sign_q, dvd_sign_d;
  logic          dvs_sign_q, dvs_sign_d;

  // Output registers
  logic [W-1:0]  quotient_mag_q, quotient_mag_d;
  logic          quotient_sign_q, quotient_sign_d;
  logic [W-1:0]  remainder_mag_q, remainder_mag_d;
  logic          remainder_sign_q, remainder_sign_d;
  logic          div_by_zero_q, div_by_zero_d;

  // One restoring step
  logic [W:0]    trial;
  logic          trial_ge;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_step;

  always_comb begin
    trial    = {rem_q, dvd_q[W-1]};
    trial_ge = (trial >= {1'b0, dvs_q});
    // When trial >= divisor the difference is < divisor, so the low W bits
    // of the subtraction are exact.
    rem_step = trial_ge ? (trial[W-1:0] - dvs_q) : trial[W-1:0];
    quo_step = {quo_q[W-2:0], trial_ge};
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dvd_d            = dvd_q;
    dvs_d            = dvs_q;
    rem_d            = rem_q;
    quo_d            = quo_q;
    dvd_sign_d       = dvd_sign_q;
    dvs_sign_d       = dvs_sign_q;
    quotient_mag_d   = quotient_mag_q;
    quotient_sign_d  = quotient_sign_q;
    remainder_mag_d  = remainder_mag_q;
    remainder_sign_d = remainder_sign_q;
    div_by_zero_d    = div_by_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d      = dividend_mag;
          dvs_d      = divisor_mag;
          dvd_sign_d = dividend_sign;
          dvs_sign_d = divisor_sign;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = CW'(W - 1);
          if (divisor_mag == '0) begin
            // Fast path: results are published on the accept edge itself.
            quotient_mag_d   = '1;
            quotient_sign_d  = 1'b1;
            remainder_mag_d  = '1;
            remainder_sign_d = 1'b1;
            div_by_zero_d    = 1'b1;
            state_d          = S_FIN;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        dvd_d = {dvd_q[W-2:0], 1'b0};
        if (cnt_q == '0) begin
          quotient_mag_d   = quo_step;
          quotient_sign_d  = sign_fix(dvd_sign_q ^ dvs_sign_q, quo_step);
          remainder_mag_d  = rem_step;
          remainder_sign_d = sign_fix(dvd_sign_q, rem_step);
          div_by_zero_d    = 1'b0;
          state_d          = S_FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      quotient_mag_q   <= '0;
      quotient_sign_q  <= 1'b0;
      remainder_mag_q  <= '0;
      remainder_sign_q <= 1'b0;
      div_by_zero_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      quotient_mag_q   <= quotient_mag_d;
      quotient_sign_q  <= quotient_sign_d;
      remainder_mag_q  <= remainder_mag_d;
      remainder_sign_q <= remainder_sign_d;
      div_by_zero_q    <= div_by_zero_d;
    end
  end

  always_ff @(posedge clk) begin
    dvd_q      <= dvd_d;
    dvs_q      <= dvs_d;
    rem_q      <= rem_d;
    quo_q      <= quo_d;
    dvd_sign_q <= dvd_sign_d;
    dvs_sign_q <= dvs_sign_d;
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign quotient_mag   = quotient_mag_q;
  assign quotient_sign  = quotient_sign_q;
  assign remainder_mag  = remainder_mag_q;
  assign remainder_sign = remainder_sign_q;
  assign div_by_zero    = div_by_zero_q;

endmodule
